// File: rtl/requant18_17_pkg.sv
// Shared widths, saturation limits and operand types for the 18->17 bit
// requantisation stage.
package requant18_17_pkg;
  localparam int IN_W    = 18;
  localparam int OUT_W   = 17;
  localparam int SH_W    = 2;
  localparam int SAT_MAX = 65535;
  localparam int SAT_MIN = -65536;

  typedef logic signed [OUT_W-1:0] neuron_t;
  // One bit wider than the input so the rounding bias cannot overflow.
  typedef logic signed [IN_W:0]    wide_t;

  localparam wide_t   SAT_MAX_W = wide_t'(SAT_MAX);
  localparam wide_t   SAT_MIN_W = wide_t'(SAT_MIN);
  localparam neuron_t OUT_MAX   = neuron_t'(SAT_MAX);
  localparam neuron_t OUT_MIN   = neuron_t'(SAT_MIN);
endpackage

// File: rtl/requant_round_sat.sv
// Combinational arithmetic: round-half-up right shift of an 18-bit sum, and
// saturation of a 19-bit shifted value to the 17-bit operand range.
module requant_round_sat
  import requant18_17_pkg::*;
(
  input  logic [IN_W-1:0] rnd_in,
  input  logic [SH_W-1:0] rnd_sh,
  output wide_t           rnd_out,
  input  wide_t           sat_in,
  output neuron_t         sat_out,
  output logic            sat_hit
);
  wide_t bias;
  wide_t sum;

  always_comb begin
    case (rnd_sh)
      2'd1:    bias = wide_t'(1);
      2'd2:    bias = wide_t'(2);
      2'd3:    bias = wide_t'(4);
      default: bias = '0;
    endcase
    sum     = $signed({rnd_in[IN_W-1], rnd_in}) + bias;
    rnd_out = sum >>> rnd_sh;
  end

  always_comb begin
    sat_out = sat_in[OUT_W-1:0];
    sat_hit = 1'b0;
    if (sat_in > SAT_MAX_W) begin
      sat_out = OUT_MAX;
      sat_hit = 1'b1;
    end else if (sat_in < SAT_MIN_W) begin
      sat_out = OUT_MIN;
      sat_hit = 1'b1;
    end
  end
endmodule

// File: rtl/requant18_17.sv
// Two-stage elastic requantiser: stage 1 rounds and shifts, stage 2
// saturates to 17 bits; also keeps a sticky flag and saturating event count.
module requant18_17
  import requant18_17_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [0:IN_W-1]  In,
  input  logic [0:SH_W-1]  sh,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [0:OUT_W-1] Out,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sat_flag,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             clr_cnt
);
  // Handshake: a beat moves across a boundary on a rising edge where valid
  // and ready are both high; valid never waits on ready, and in_ready depends
  // only on held state and out_ready, never on in_valid.
  logic [IN_W-1:0] in_vec;
  logic [SH_W-1:0] sh_vec;
  wide_t           v1_next;
  neuron_t         sat_val;
  logic            sat_hit;

  logic             s1_valid_q, s1_valid_d;
  wide_t            v1_q, v1_d;
  logic             s2_valid_q, s2_valid_d;
  neuron_t          out_q, out_d;
  logic             out_sat_q, out_sat_d;
  logic             sat_flag_q, sat_flag_d;
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  logic s1_load;
  logic s2_load;
  logic sat_event;

  assign in_vec = In;
  assign sh_vec = sh;

  requant_round_sat u_round_sat (
    .rnd_in  (in_vec),
    .rnd_sh  (sh_vec),
    .rnd_out (v1_next),
    .sat_in  (v1_q),
    .sat_out (sat_val),
    .sat_hit (sat_hit)
  );

  assign s2_load   = s1_valid_q && (!s2_valid_q || out_ready);
  assign in_ready  = !s1_valid_q || s2_load;
  assign s1_load   = in_valid && in_ready;
  assign sat_event = s2_load && sat_hit;

  always_comb begin
    s1_valid_d = s1_valid_q;
    v1_d       = v1_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    out_sat_d  = out_sat_q;
    sat_flag_d = sat_flag_q;
    sat_cnt_d  = sat_cnt_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      v1_d       = v1_next;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      out_d      = sat_val;
      out_sat_d  = sat_hit;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end

    // Clear takes priority and swallows any event landing in the same cycle.
    if (clr_cnt) begin
      sat_flag_d = 1'b0;
      sat_cnt_d  = '0;
    end else if (sat_event) begin
      sat_flag_d = 1'b1;
      if (sat_cnt_q != {CNT_W{1'b1}}) sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      v1_q       <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      out_sat_q  <= 1'b0;
      sat_flag_q <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      v1_q       <= v1_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      out_sat_q  <= out_sat_d;
      sat_flag_q <= sat_flag_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign Out       = out_q;
  assign out_sat   = out_sat_q;
  assign out_valid = s2_valid_q;
  assign sat_flag  = sat_flag_q;
  assign sat_cnt   = sat_cnt_q;
endmodule

// File: tb/tb_requant18_17.sv
// Bench for requant18_17: directed rounding/saturation vectors, counter and
// clear behaviour, backpressure, throughput and reset, with a scoreboard.
module tb_requant18_17;
  logic        clk;
  logic        rst_n;
  logic [0:17] in_d;
  logic [0:1]  sh_d;
  logic        in_valid;
  logic        in_ready;
  logic [0:16] out_w;
  logic        out_sat;
  logic        out_valid;
  logic        out_ready;
  logic        sat_flag;
  logic [7:0]  sat_cnt;
  logic        clr_cnt;

  int          n_cmp;
  int          n_err;
  logic [17:0] exp_q[$];
  int          occ;
  bit          mon_en;
  bit          prev_stall;
  logic [17:0] held;
  int          full_seen;

  requant18_17 #(.CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .In        (in_d),
    .sh        (sh_d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Out       (out_w),
    .out_sat   (out_sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat_flag  (sat_flag),
    .sat_cnt   (sat_cnt),
    .clr_cnt   (clr_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference: round-half-up divide by 2^s using floor division, then clamp.
  function automatic logic [17:0] model(input logic [17:0] x, input logic [1:0] s);
    int v, d, r, q;
    logic [16:0] o;
    logic sat;
    v = int'($signed(x));
    d = 1 << s;
    r = v + ((s == 2'd0) ? 0 : d / 2);
    q = r / d;
    if ((r % d) != 0 && r < 0) q = q - 1;
    if (q > 65535) begin
      o = 17'h0ffff; sat = 1'b1;
    end else if (q < -65536) begin
      o = 17'h10000; sat = 1'b1;
    end else begin
      o = q[16:0]; sat = 1'b0;
    end
    return {sat, o};
  endfunction

  // scoreboard monitor: samples on the falling edge, transfers happen on the next rising edge
  always @(negedge clk) begin
    logic [16:0] o;
    logic [17:0] obs, expv, xin;
    if (rst_n && mon_en) begin
      o   = out_w;
      obs = {out_sat, o};
      if (prev_stall) begin
        n_cmp++;
        if (!out_valid || obs !== held) begin
          n_err++;
          $display("FAIL stall_hold: got valid=%0b data=%h, required valid=1 data=%h", out_valid, obs, held);
        end
      end
      n_cmp++;
      if (in_ready !== ((occ < 2) || out_ready)) begin
        n_err++;
        $display("FAIL in_ready: got %0b, required %0b (occ=%0d out_ready=%0b)", in_ready, ((occ < 2) || out_ready), occ, out_ready);
      end
      if (occ == 2 && !out_ready) full_seen++;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got %h with empty scoreboard", obs);
        end else begin
          expv = exp_q.pop_front();
          if (obs !== expv) begin
            n_err++;
            $display("FAIL scoreboard: got sat=%0b out=%h, required sat=%0b out=%h", obs[17], obs[16:0], expv[17], expv[16:0]);
          end
        end
        occ--;
      end
      if (in_valid && in_ready) begin
        xin = in_d;
        exp_q.push_back(model(xin, sh_d));
        occ++;
      end
      prev_stall = out_valid && !out_ready;
      held       = obs;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // driver tasks
  task automatic send(input logic [17:0] x, input logic [1:0] s);
    bit done;
    done = 1'b0;
    in_d = x;
    sh_d = s;
    in_valid = 1'b1;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL send_timeout: beat %h not accepted, required acceptance within 100 cycles", x);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || out_valid) begin
      n_err++;
      $display("FAIL drain: %0d beats still pending, required 0", exp_q.size());
    end
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    clr_cnt = 1'b0;
  endtask

  // Single beat into an empty pipe: out_valid must appear exactly 2 cycles later.
  task automatic send_timed(input logic [17:0] x, input logic [1:0] s,
                            input logic [16:0] eo, input logic esat, input string name);
    logic [16:0] o;
    send(x, s);
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_early: got out_valid=%0b after 1 cycle, required 0", name, out_valid);
    end
    @(negedge clk);
    o = out_w;
    n_cmp++;
    if (out_valid !== 1'b1 || o !== eo || out_sat !== esat) begin
      n_err++;
      $display("FAIL %s: got valid=%0b out=%h sat=%0b, required valid=1 out=%h sat=%0b", name, out_valid, o, out_sat, eo, esat);
    end
    wait_drain();
  endtask

  task automatic test_reset();
    logic [16:0] o;
    #3;
    o = out_w;
    n_cmp++;
    if (out_valid !== 1'b0 || o !== 17'h0 || out_sat !== 1'b0 || sat_flag !== 1'b0 || sat_cnt !== 8'h0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%0b out=%h sat=%0b flag=%0b cnt=%0d, required all 0", out_valid, o, out_sat, sat_flag, sat_cnt);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_round();
    send_timed(18'd1000, 2'd0, 17'd1000, 1'b0, "sh0_1000");
    send_timed(18'd131071, 2'd1, 17'h0ffff, 1'b1, "sh1_max");
    send_timed(-18'sd131072, 2'd1, 17'h10000, 1'b0, "sh1_min");
    n_cmp++;
    if (sat_cnt !== 8'd1 || sat_flag !== 1'b1) begin
      n_err++;
      $display("FAIL sh1_counter: got cnt=%0d flag=%0b, required cnt=1 flag=1", sat_cnt, sat_flag);
    end
    send_timed(18'd5, 2'd2, 17'd1, 1'b0, "sh2_p5");
    send_timed(-18'sd6, 2'd2, -17'sd1, 1'b0, "sh2_m6");
    send_timed(-18'sd7, 2'd2, -17'sd2, 1'b0, "sh2_m7");
    send_timed(18'd4, 2'd3, 17'd1, 1'b0, "sh3_half");
  endtask

  task automatic test_sat_clear();
    pulse_clr();
    n_cmp++;
    if (sat_cnt !== 8'd0 || sat_flag !== 1'b0) begin
      n_err++;
      $display("FAIL clr_idle: got cnt=%0d flag=%0b, required 0/0", sat_cnt, sat_flag);
    end
    send_timed(18'd70000, 2'd0, 17'h0ffff, 1'b1, "sat_pos");
    send_timed(-18'sd70000, 2'd0, 17'h10000, 1'b1, "sat_neg");
    n_cmp++;
    if (sat_cnt !== 8'd2 || sat_flag !== 1'b1) begin
      n_err++;
      $display("FAIL sat_count2: got cnt=%0d flag=%0b, required cnt=2 flag=1", sat_cnt, sat_flag);
    end
    // Beat accepted on the last edge; it enters stage 2 on the next one, with clear.
    send(18'd70000, 2'd0);
    pulse_clr();
    n_cmp++;
    if (sat_cnt !== 8'd0 || sat_flag !== 1'b0) begin
      n_err++;
      $display("FAIL clr_wins: got cnt=%0d flag=%0b, required 0/0", sat_cnt, sat_flag);
    end
    wait_drain();
    n_cmp++;
    if (sat_cnt !== 8'd0 || sat_flag !== 1'b0) begin
      n_err++;
      $display("FAIL clr_dropped: got cnt=%0d flag=%0b, required 0/0", sat_cnt, sat_flag);
    end
  endtask

  task automatic test_back_to_back();
    time t0;
    out_ready = 1'b1;
    t0 = $time;
    for (int i = 0; i < 20; i++) send(18'($urandom_range(0, 262143)), 2'($urandom_range(0, 3)));
    n_cmp++;
    if (($time - t0) != 200) begin
      n_err++;
      $display("FAIL throughput: 20 beats took %0t, required 200", $time - t0);
    end
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    pat = 4'b1001;
    full_seen = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(18'($urandom_range(0, 262143)), 2'($urandom_range(0, 3)));
      end
      begin
        for (int c = 0; c < 40; c++) begin
          out_ready = pat[c % 4];
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    n_cmp++;
    if (full_seen == 0) begin
      n_err++;
      $display("FAIL bp_full: got 0 cycles with both stages full, required at least 1");
    end
  endtask

  task automatic test_counter_limit();
    pulse_clr();
    for (int i = 0; i < 300; i++) send((i % 2 == 0) ? 18'd70000 : -18'sd70000, 2'd0);
    wait_drain();
    n_cmp++;
    if (sat_cnt !== 8'hff || sat_flag !== 1'b1) begin
      n_err++;
      $display("FAIL cnt_limit: got cnt=%0d flag=%0b, required cnt=255 flag=1", sat_cnt, sat_flag);
    end
  endtask

  task automatic test_reset_midstream();
    logic [16:0] o;
    mon_en    = 1'b0;
    out_ready = 1'b0;
    send(18'd100, 2'd0);
    send(18'd200, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    o = out_w;
    n_cmp++;
    if (out_valid !== 1'b0 || o !== 17'h0 || out_sat !== 1'b0 || sat_flag !== 1'b0 || sat_cnt !== 8'h0) begin
      n_err++;
      $display("FAIL async_reset: got valid=%0b out=%h sat=%0b flag=%0b cnt=%0d, required all 0", out_valid, o, out_sat, sat_flag, sat_cnt);
    end
    exp_q.delete();
    occ       = 0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    send_timed(-18'sd300, 2'd1, -17'sd150, 1'b0, "post_reset");
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    occ       = 0;
    mon_en    = 1'b0;
    full_seen = 0;
    rst_n     = 1'b0;
    in_d      = '0;
    sh_d      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;

    test_reset();
    test_round();
    test_sat_clear();
    test_back_to_back();
    test_backpressure();
    test_counter_limit();
    test_reset_midstream();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
